// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM image loader and its peers on the data-RAM
// bus (memory, DMA, arbiter).
//   DATA_W / ADDR_W : data RAM geometry (10-bit words, 14-bit addresses)
//   loader_state_t  : loader FSM encoding
package ram_loader_pkg;
  localparam int DATA_W     = 10;
  localparam int ADDR_W     = 14;
  localparam int FIFO_DEPTH = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;
endpackage

// File: rtl/loader_fifo.sv
// Small synchronous show-ahead FIFO buffering loader input words.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata : write one entry (caller guarantees not full)
//   pop        : drop the head entry (caller guarantees not empty)
//   head       : current oldest entry, valid whenever !empty, no read latency
//   full/empty : occupancy flags
// Push and pop on the same edge are allowed at any occupancy.
module loader_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]   mem_q [DEPTH];
  logic [W-1:0]   mem_d [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/ram_image_loader.sv
// Streams a memory image into the shared data RAM through the bus arbiter.
//   clk, rst           : clock, asynchronous active-low reset
//   start, base_addr,
//   length             : job command, sampled only when idle
//   in_valid/in_data/
//   in_ready           : input word stream
//   req/grant          : arbiter handshake; one write per granted cycle
//   ram_write/ram_addr/
//   ram_indata         : RAM write port
//   busy/done          : job status; done is a one-cycle pulse
//   words_written      : words committed in the current/last job
module ram_image_loader
  import ram_loader_pkg::*;
#(
  parameter int DATA_W     = ram_loader_pkg::DATA_W,
  parameter int ADDR_W     = ram_loader_pkg::ADDR_W,
  parameter int FIFO_DEPTH = ram_loader_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              req,
  input  logic              grant,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_indata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] words_written
);
  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [ADDR_W-1:0] to_accept_q, to_accept_d;
  logic [ADDR_W-1:0] words_written_q, words_written_d;

  logic              fifo_full, fifo_empty, push;
  logic [DATA_W-1:0] fifo_head;
  logic              in_load;

  assign in_load  = (state_q == LOAD);
  // to_accept caps intake at length so surplus input words are never taken.
  assign in_ready = in_load && !fifo_full && (to_accept_q != '0);
  assign push     = in_valid && in_ready;
  // Purely flop-derived so the arbiter sees a glitch-free request.
  assign req       = in_load && !fifo_empty;
  assign ram_write = req && grant;
  assign ram_addr   = in_load ? cur_addr_q : '0;
  assign ram_indata = in_load ? fifo_head  : '0;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign words_written = words_written_q;

  loader_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .wdata (in_data),
    .pop   (ram_write),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    remaining_d     = remaining_q;
    to_accept_d     = to_accept_q;
    words_written_d = words_written_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_addr_d      = base_addr;
          remaining_d     = length;
          to_accept_d     = length;
          words_written_d = '0;
          state_d         = (length == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (push) to_accept_d = to_accept_q - ADDR_W'(1);
        if (ram_write) begin
          // Address wraps modulo 2^ADDR_W by natural overflow.
          cur_addr_d      = cur_addr_q + ADDR_W'(1);
          remaining_d     = remaining_q - ADDR_W'(1);
          words_written_d = words_written_q + ADDR_W'(1);
        end
        if (remaining_q == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cur_addr_q      <= '0;
      remaining_q     <= '0;
      to_accept_q     <= '0;
      words_written_q <= '0;
    end else begin
      state_q         <= state_d;
      cur_addr_q      <= cur_addr_d;
      remaining_q     <= remaining_d;
      to_accept_q     <= to_accept_d;
      words_written_q <= words_written_d;
    end
  end
endmodule

// File: tb/tb_ram_image_loader.sv
// Randomized bench for ram_image_loader with a transaction-level model:
// job progress is tracked as counts of accepted and written words.
module tb_ram_image_loader;
  import ram_loader_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  start = 1'b0;
  addr_t base_addr = '0, length = '0;
  logic  in_valid = 1'b0;
  data_t in_data = '0;
  logic  grant = 1'b0;
  logic  in_ready, req, ram_write, busy, done;
  addr_t ram_addr, words_written;
  data_t ram_indata;

  ram_image_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .req(req),
    .grant(grant), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_indata(ram_indata), .busy(busy), .done(done),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int    m_phase = 0;        // 0 idle, 1 loading, 2 completion cycle
  int    m_len = 0, m_acc = 0, m_wr = 0;
  addr_t m_base = '0;
  data_t m_q [64];
  int    cyc_n = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0, n_acc_tb = 0;
  addr_t log_addr [$];
  data_t log_data [$];
  int    log_cyc  [$];

  always @(negedge clk) begin
    bit ld, e_ir, e_req, e_wr;
    cyc_n++;
    if (!rst) begin
      m_phase = 0; m_acc = 0; m_wr = 0; m_len = 0;
      chk("reset_outputs",
          32'({in_ready, req, ram_write, busy, done, ram_addr, ram_indata, words_written}), 32'(0));
    end else begin
      ld    = (m_phase == 1);
      e_ir  = ld && (m_acc - m_wr) < FIFO_DEPTH && m_acc < m_len;
      e_req = ld && m_acc > m_wr;
      e_wr  = e_req && grant;
      chk("in_ready", 32'(in_ready), 32'(e_ir));
      chk("req", 32'(req), 32'(e_req));
      chk("ram_write", 32'(ram_write), 32'(e_wr));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("done", 32'(done), 32'(m_phase == 2));
      chk("words_written", 32'(words_written), 32'(m_wr));
      if (m_phase == 0) chk("idle_bus", 32'({ram_addr, ram_indata}), 32'(0));
      if (ram_write && e_wr) begin
        chk("ram_addr", 32'(ram_addr), 32'(addr_t'(m_base + addr_t'(m_wr))));
        chk("ram_indata", 32'(ram_indata), 32'(m_q[m_wr]));
        log_addr.push_back(ram_addr);
        log_data.push_back(ram_indata);
        log_cyc.push_back(cyc_n);
      end
      if (in_valid && in_ready) n_acc_tb++;
      case (m_phase)
        0: if (start) begin
          m_base = base_addr; m_len = int'(length); m_acc = 0; m_wr = 0;
          start_cyc = cyc_n;
          m_phase = (m_len == 0) ? 2 : 1;
        end
        1: begin
          if (m_wr == m_len) m_phase = 2;
          if (in_valid && e_ir) begin
            if (m_acc < 64) m_q[m_acc] = in_data;
            m_acc++;
          end
          if (e_wr) m_wr++;
        end
        default: begin
          m_phase = 0; done_cnt++; done_cyc = cyc_n;
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic logic gpat(input int gmode, input int k);
    bit [5:0] pat = 6'b101001;   // 1,0,0,1,0,1 from bit 0 upward
    case (gmode)
      0: return 1'b1;
      1: return pat[k % 6];
      2: return 1'($urandom_range(0, 2) != 0);
      default: return (k >= 10);
    endcase
  endfunction

  // Runs one job; returns number of words accepted during the grant-0
  // window (cycles 0..9) for the backpressure case.
  task automatic run_job(input addr_t b, input addr_t l, input int gmode,
                         input int vmode, input bit misuse, input data_t dbase,
                         output int acc_at10);
    int acc0, d0;
    bit fin;
    acc0 = n_acc_tb; d0 = done_cnt; fin = 0; acc_at10 = 0;
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    start = 1; base_addr = b; length = l; in_valid = 0; grant = 0;
    cyc();
    for (int k = 0; k < 400; k++) begin
      start = misuse && (k == 2);
      if (start) begin base_addr = 14'h2222; length = 14'd9; end
      grant    = gpat(gmode, k);
      in_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 9) < 7);
      in_data  = dbase + data_t'(n_acc_tb - acc0);
      if (k == 10) acc_at10 = n_acc_tb - acc0;
      cyc();
      if (done_cnt != d0) begin fin = 1; break; end
    end
    start = 0;
    if (!fin) chk("job_timeout", 32'(0), 32'(1));
    // Extra words offered after the job: must be ignored.
    in_valid = 1;
    cyc(); cyc();
    in_valid = 0; grant = 0;
    chk("accepted_eq_length", 32'(n_acc_tb - acc0), 32'(l));
  endtask

  initial begin
    int a10, d0;
    // Reset state
    #1;
    chk("por_zero",
        32'({in_ready, req, ram_write, busy, done, ram_addr, ram_indata, words_written}), 32'(0));
    cyc(); cyc();
    rst = 1;
    cyc();

    // Basic burst
    run_job(14'h0010, 14'd4, 0, 0, 0, 10'h001, a10);
    chk("burst_nwrites", 32'(log_addr.size()), 32'(4));
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk("burst_addr", 32'(log_addr[i]), 32'(14'h0010 + i));
      chk("burst_data", 32'(log_data[i]), 32'(i + 1));
      chk("burst_consecutive", 32'(log_cyc[i] - log_cyc[0]), 32'(i));
    end
    chk("burst_ww", 32'(words_written), 32'(4));
    chk("burst_busy_low", 32'(busy), 32'(0));

    // Grant throttling
    run_job(14'h0100, 14'd3, 1, 0, 0, 10'h055, a10);
    chk("throttle_nwrites", 32'(log_addr.size()), 32'(3));
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      chk("throttle_addr", 32'(log_addr[i]), 32'(14'h0100 + i));
      chk("throttle_data", 32'(log_data[i]), 32'(10'h055 + i));
    end

    // Backpressure: grant held low 10 cycles
    run_job(14'h0200, 14'd8, 3, 0, 0, 10'h300, a10);
    chk("bp_accepts_while_stalled", 32'(a10), 32'(4));
    chk("bp_nwrites", 32'(log_addr.size()), 32'(8));
    for (int i = 0; i < 8 && i < log_addr.size(); i++)
      chk("bp_data", 32'(log_data[i]), 32'(10'h300 + i));

    // Address wrap
    run_job(14'h3FFE, 14'd3, 0, 0, 0, 10'h3F0, a10);
    chk("wrap_n", 32'(log_addr.size()), 32'(3));
    if (log_addr.size() == 3) begin
      chk("wrap_a0", 32'(log_addr[0]), 32'(14'h3FFE));
      chk("wrap_a1", 32'(log_addr[1]), 32'(14'h3FFF));
      chk("wrap_a2", 32'(log_addr[2]), 32'(14'h0000));
    end

    // Zero length
    run_job(14'h0040, 14'd0, 0, 0, 0, 10'h000, a10);
    chk("len0_nwrites", 32'(log_addr.size()), 32'(0));
    chk("len0_done_latency", 32'(done_cyc - start_cyc), 32'(1));

    // Misuse: start during LOAD plus surplus words
    run_job(14'h0500, 14'd4, 2, 0, 1, 10'h111, a10);
    chk("misuse_ww", 32'(words_written), 32'(4));
    chk("misuse_nwrites", 32'(log_addr.size()), 32'(4));
    for (int i = 0; i < 4 && i < log_addr.size(); i++)
      chk("misuse_addr", 32'(log_addr[i]), 32'(14'h0500 + i));

    // Reset mid-job after 2 of 5 writes
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    start = 1; base_addr = 14'h0600; length = 14'd5; in_valid = 1; grant = 1;
    in_data = 10'h0AA;
    cyc();
    start = 0;
    for (int k = 0; k < 50; k++) begin
      if (log_addr.size() >= 2) break;
      in_data = in_data + 10'd1;
      cyc();
    end
    chk("rst_mid_reached2", 32'(log_addr.size()), 32'(2));
    #2 rst = 0;
    #1;
    chk("rst_async_zero",
        32'({in_ready, req, ram_write, busy, done, ram_addr, ram_indata, words_written}), 32'(0));
    cyc();
    rst = 1; in_valid = 0; grant = 0;
    d0 = done_cnt;
    for (int k = 0; k < 10; k++) cyc();
    chk("rst_no_done", 32'(done_cnt), 32'(d0));
    chk("rst_no_more_writes", 32'(log_addr.size()), 32'(2));
    run_job(14'h0700, 14'd1, 0, 0, 0, 10'h077, a10);
    chk("post_rst_write", 32'({log_addr.size() == 1, log_addr.size() == 1 ? log_addr[0] : 14'h0}),
        32'({1'b1, 14'h0700}));

    // Random jobs
    for (int j = 0; j < 25; j++)
      run_job(addr_t'($urandom), addr_t'($urandom_range(0, 12)), 2, 1, 1'($urandom_range(0, 1)),
              data_t'($urandom), a10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_image_loader.md
Name: ram_image_loader

Overview:
- Streams a memory image into the shared 10-bit × 14-bit data RAM. It is the write-side counterpart of the RAM dump path.
- Accepts words over a valid/ready input stream and buffers them in a small FIFO.
- Writes them to consecutive RAM addresses starting at a programmed base. Every write is issued through the existing request/grant bus arbiter, as a peer of the DMA and cache masters.
- Used to preload data memory before releasing the core, and by benches to inject RAM contents mid-run.

Parameters:
DATA_W, 10, RAM word width
ADDR_W, 14, RAM address width; also the width of the length and word counters
FIFO_DEPTH, 4, input buffer entries; power of two, at least 2

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  one-cycle command pulse; sampled only in IDLE
base_addr  in  ADDR_W  first RAM address; latched on accepted start
length  in  ADDR_W  number of words to load; latched on accepted start
in_valid  in  1  input word present
in_data  in  DATA_W  input word
in_ready  out  1  loader accepts in_data this cycle
req  out  1  bus request to arbiter
grant  in  1  arbiter grant; may drop on any cycle
ram_write  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM write address
ram_indata  out  DATA_W  RAM write data
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
words_written  out  ADDR_W  words committed to RAM in the current/last job

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; FIFO emptied; all counters cleared. All outputs 0: in_ready, req, ram_write, ram_addr, ram_indata, busy, done, words_written.
- Reset mid-job abandons the job. No further RAM writes occur and no done pulse is produced.
- FSM states are IDLE, LOAD, DONE.
- IDLE → LOAD on start=1. Action: latch base_addr into cur_addr and length into remaining and to_accept; clear words_written.
- IDLE → DONE on start=1 with length=0. No writes are issued.
- start in LOAD or DONE is ignored.
- LOAD → DONE in the cycle after remaining reaches 0.
- DONE → IDLE unconditionally after 1 cycle. done=1 only while in DONE; busy=1 in LOAD and DONE.
- Input side:
  - in_ready = (state==LOAD) & FIFO not full & (to_accept != 0).
  - A word is accepted when in_valid & in_ready; it is pushed to the FIFO and to_accept is decremented.
  - Words beyond length are never accepted, so in_ready stays 0.
- Write side:
  - req = (state==LOAD) & FIFO not empty. req is registered-state derived and glitch-free.
  - ram_write = req & grant, combinational.
  - ram_addr = cur_addr and ram_indata = FIFO head. Both are driven at all times in LOAD; they are 0 in IDLE.
  - On each cycle with ram_write=1: pop the FIFO, cur_addr+1, remaining−1, words_written+1.
  - A held grant yields one write per cycle (burst). A dropped grant stalls writes with no loss.
- Latency: a word accepted at edge N can be written in cycle N+1 at the earliest, given grant.
- Simultaneous push and pop are allowed on the same edge in every FIFO occupancy state, including full (pop frees a slot; in_ready is computed before the edge, so it is 0 when full) and empty (no pop, because req=0).
- Address wrap-around: cur_addr increments modulo 2^ADDR_W. 3FFF+1 → 0000 with no error flag.
- words_written holds its final value after done until the next accepted start.

Decomposition:
- Package ram_loader_pkg holds:
  - localparams DATA_W=10 and ADDR_W=14, shared with the memory module, DMA and arbiter.
  - typedef enum logic [1:0] loader_state_t {IDLE, LOAD, DONE}.
  - typedefs data_t and addr_t.
- One sub-module, loader_fifo: synchronous FIFO with async active-low reset. It has push/pop, full/empty and a head output (show-ahead, no read latency).
- FSM, counters and handshake logic stay in ram_image_loader.

Test Plan:
- Basic burst: start with base=0x0010, length=4, grant held 1; stream 0x001,0x002,0x003,0x004 back-to-back → writes at 0x0010..0x0013 on consecutive cycles with matching data; done pulses once; words_written=4; busy then 0.
- Grant throttling: length=3, grant toggling 1,0,0,1,0,1 → writes occur only in grant=1 cycles; data order is preserved; no duplicate or missing address.
- Backpressure / FIFO full: grant=0 for 10 cycles while in_valid=1 → in_ready drops after 4 accepts; once grant=1, all 4 are written, then the remaining words are accepted.
- Boundaries:
  - base=0x3FFE, length=3 → writes at 0x3FFE, 0x3FFF, 0x0000.
  - length=0 → done 1 cycle after start; no req or ram_write.
- Protocol misuse: start pulsed during LOAD, and 2 extra in_valid words after length is reached → both ignored; in_ready=0 for the extras; words_written equals length.
- Reset mid-job: assert rst=0 after 2 of 5 writes → all outputs 0 immediately (asynchronous); after release, no done pulse; a new start with length=1 completes normally.
